// File: rtl/flag_branch_resolver_if.sv
// Branch-resolver bus: flag writes from execute, branch requests in, fetch redirect out.
interface flag_branch_resolver_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             flag_we;
  logic             gt_in;
  logic             eq_in;
  logic             br_valid;
  logic             br_ready;
  logic             isBeq;
  logic             isBgt;
  logic             isUBranch;
  logic             isRet;
  logic [PC_W-1:0]  branchTarget;
  logic [PC_W-1:0]  ra_value;
  logic             res_valid;
  logic             isBranchTaken;
  logic [PC_W-1:0]  branchPC;
  logic             flush;
  logic             flags_gt;
  logic             flags_eq;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output flag_we, gt_in, eq_in, br_valid, isBeq, isBgt, isUBranch, isRet,
           branchTarget, ra_value,
    input  br_ready, res_valid, isBranchTaken, branchPC, flush,
           flags_gt, flags_eq, taken_count
  );

  modport slave (
    input  flag_we, gt_in, eq_in, br_valid, isBeq, isBgt, isUBranch, isRet,
           branchTarget, ra_value,
    output br_ready, res_valid, isBranchTaken, branchPC, flush,
           flags_gt, flags_eq, taken_count
  );
endinterface

// File: rtl/flag_branch_resolver.sv
// Flags register plus one-deep branch resolver, one-cycle resolve latency.
// FLAG_FWD_EN forwards same-cycle compare flags; otherwise a flag hazard stalls one cycle.
module flag_branch_resolver #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  flag_branch_resolver_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} state_t;
  typedef enum logic [2:0] {K_NONE, K_BEQ, K_BGT, K_UBR, K_RET} kind_t;

  state_t           r_state;
  state_t           w_next;
  kind_t            r_kind;
  kind_t            w_kind;
  logic [PC_W-1:0]  r_pc;
  logic             r_gt;
  logic             r_eq;
  logic             r_flags_gt;
  logic             r_flags_eq;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ready;
  logic             w_accept;
  logic             w_res_valid;
  logic             w_taken;
  logic [PC_W-1:0]  w_pc;

  // Priority decode of the request type: ret > b/call > beq > bgt.
  always_comb begin
    w_kind = K_NONE;
    if (bus.isRet)          w_kind = K_RET;
    else if (bus.isUBranch) w_kind = K_UBR;
    else if (bus.isBeq)     w_kind = K_BEQ;
    else if (bus.isBgt)     w_kind = K_BGT;
  end

  assign w_ready  = !i_reset && (r_state != S_WAIT);
  assign w_accept = bus.br_valid && w_ready;

`ifndef FLAG_FWD_EN
  logic w_hazard;
  assign w_hazard = bus.flag_we && ((w_kind == K_BEQ) || (w_kind == K_BGT));
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE, S_RESOLVE: begin
        if (w_accept) begin
`ifdef FLAG_FWD_EN
          w_next = S_RESOLVE;
`else
          w_next = w_hazard ? S_WAIT : S_RESOLVE;
`endif
        end
      end
      S_WAIT:  w_next = S_RESOLVE;
      default: w_next = S_IDLE;
    endcase
  end

  // The effective flags are captured at acceptance so later flag writes
  // (during a stall or the resolve cycle) cannot alter this decision.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_kind <= K_NONE;
      r_pc   <= '0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
    end else if (w_accept) begin
      r_kind <= w_kind;
      r_pc   <= (w_kind == K_RET) ? bus.ra_value : bus.branchTarget;
      r_gt   <= bus.flag_we ? bus.gt_in : r_flags_gt;
      r_eq   <= bus.flag_we ? bus.eq_in : r_flags_eq;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags_gt <= 1'b0;
      r_flags_eq <= 1'b0;
    end else if (bus.flag_we) begin
      r_flags_gt <= bus.gt_in;
      r_flags_eq <= bus.eq_in;
    end
  end

  always_comb begin
    w_res_valid = (r_state == S_RESOLVE) && !i_reset;
    w_taken     = 1'b0;
    if (w_res_valid) begin
      case (r_kind)
        K_RET, K_UBR: w_taken = 1'b1;
        K_BEQ:        w_taken = r_eq;
        K_BGT:        w_taken = r_gt;
        default:      w_taken = 1'b0;
      endcase
    end
    w_pc = w_taken ? r_pc : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_taken && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.br_ready      = w_ready;
  assign bus.res_valid     = w_res_valid;
  assign bus.isBranchTaken = w_taken;
  assign bus.branchPC      = w_pc;
  assign bus.flush         = w_taken;
  assign bus.flags_gt      = r_flags_gt;
  assign bus.flags_eq      = r_flags_eq;
  assign bus.taken_count   = r_cnt;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Bench for flag_branch_resolver: directed plan steps plus random traffic against a queue-based model.
module tb_flag_branch_resolver;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flag_branch_resolver_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  flag_branch_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    bit          taken;
    logic [31:0] pc;
  } res_t;

  res_t q[$];
  int   cyc = 0;
  int   m_cnt = 0;
  bit   m_gt = 1'b0, m_eq = 1'b0, m_stall = 1'b0;
  int   total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.flag_we = 1'b0; bus.gt_in = 1'b0; bus.eq_in = 1'b0;
    bus.br_valid = 1'b0; bus.isRet = 1'b0; bus.isUBranch = 1'b0;
    bus.isBeq = 1'b0; bus.isBgt = 1'b0;
    bus.branchTarget = '0; bus.ra_value = '0;
  endtask

  // t = {ret, ubranch, beq, bgt}
  task automatic req(input logic [3:0] t, input logic [31:0] tgt, input logic [31:0] ra);
    bus.br_valid = 1'b1;
    bus.isRet = t[3]; bus.isUBranch = t[2]; bus.isBeq = t[1]; bus.isBgt = t[0];
    bus.branchTarget = tgt; bus.ra_value = ra;
  endtask

  task automatic flagw(input bit gt, input bit eq);
    bus.flag_we = 1'b1; bus.gt_in = gt; bus.eq_in = eq;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then move past the edge.
  task automatic step();
    bit          due, rv, tk, rdy, cond, taken, hz, geff, eeff;
    logic [31:0] pc, tpc;
    res_t        e;
    @(negedge clk);
    due = (q.size() > 0) && (q[0].due == cyc);
    e = '{0, 1'b0, 32'h0};
    if (due) e = q[0];
    rv  = due && !reset;
    tk  = rv && e.taken;
    pc  = tk ? e.pc : 32'h0;
    rdy = !reset && !m_stall;
    check("res_valid", {31'h0, bus.res_valid}, {31'h0, rv});
    check("taken", {31'h0, bus.isBranchTaken}, {31'h0, tk});
    check("branchPC", bus.branchPC, pc);
    check("flush", {31'h0, bus.flush}, {31'h0, tk});
    check("br_ready", {31'h0, bus.br_ready}, {31'h0, rdy});
    check("flags_gt", {31'h0, bus.flags_gt}, {31'h0, m_gt});
    check("flags_eq", {31'h0, bus.flags_eq}, {31'h0, m_eq});
    check("taken_count", 32'(bus.taken_count), 32'(m_cnt));
    if (due) void'(q.pop_front());
    if (reset) begin
      m_gt = 1'b0; m_eq = 1'b0; m_cnt = 0; m_stall = 1'b0;
      q.delete();
    end else begin
      if (tk && m_cnt < CMAX) m_cnt++;
      m_stall = 1'b0;
      if (bus.br_valid && rdy) begin
        geff = bus.flag_we ? bus.gt_in : m_gt;
        eeff = bus.flag_we ? bus.eq_in : m_eq;
        cond = 1'b0; taken = 1'b0; tpc = 32'h0;
        if (bus.isRet) begin
          taken = 1'b1; tpc = bus.ra_value;
        end else if (bus.isUBranch) begin
          taken = 1'b1; tpc = bus.branchTarget;
        end else if (bus.isBeq) begin
          cond = 1'b1; taken = eeff; tpc = bus.branchTarget;
        end else if (bus.isBgt) begin
          cond = 1'b1; taken = geff; tpc = bus.branchTarget;
        end
        hz = cond && bus.flag_we && !FWD;
        q.push_back('{cyc + (hz ? 2 : 1), taken, taken ? tpc : 32'h0});
        m_stall = hz;
      end
      if (bus.flag_we) begin
        m_gt = bus.gt_in; m_eq = bus.eq_in;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] t;
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;
    step();

    // compare then branch
    flagw(1'b0, 1'b1); step();
    idle(); step();
    req(4'b0010, 32'h40, 32'h0); step();
    req(4'b0001, 32'h80, 32'h0); step();
    idle(); step(); step();

    // same-cycle hazard: eq goes 0 -> 1 while beq is accepted
    flagw(1'b0, 1'b0); step();
    flagw(1'b0, 1'b1); req(4'b0010, 32'h100, 32'h0); step();
    idle(); step(); step(); step();

    // back-to-back call / ret / b from a clean counter
    reset = 1'b1; step(); reset = 1'b0;
    req(4'b0100, 32'h200, 32'h0); step();
    req(4'b1000, 32'h0, 32'h1234); step();
    req(4'b0100, 32'h300, 32'h0); step();
    idle(); step(); step();
    check("b2b_count", 32'(bus.taken_count), 32'd3);

    // priority and illegal requests
    req(4'b1100, 32'h20, 32'h10); step();
    req(4'b0000, 32'h55, 32'h66); step();
    idle(); step(); step();

    // saturation
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      req(4'b0100, 32'h1000 + 32'(i), 32'h0); step();
    end
    idle(); step(); step();
    check("sat_count", 32'(bus.taken_count), 32'(CMAX));
    req(4'b0100, 32'h2000, 32'h0); step();
    idle(); step(); step();
    check("sat_hold", 32'(bus.taken_count), 32'(CMAX));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      bus.flag_we = ($urandom_range(0, 2) == 0);
      bus.gt_in = 1'($urandom_range(0, 1));
      bus.eq_in = 1'($urandom_range(0, 1));
      bus.br_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0, 1:    t = 4'b0010;
        2, 3:    t = 4'b0001;
        4, 5:    t = 4'b0100;
        6:       t = 4'b1000;
        7:       t = 4'b0000;
        default: t = 4'($urandom_range(0, 15));
      endcase
      bus.isRet = t[3]; bus.isUBranch = t[2]; bus.isBeq = t[1]; bus.isBgt = t[0];
      bus.branchTarget = $urandom;
      bus.ra_value = $urandom;
      step();
    end

    // request accepted just before reset must never report a result
    reset = 1'b0; idle(); step(); step();
    flagw(1'b1, 1'b1); req(4'b0100, 32'h400, 32'h0); step();
    idle(); reset = 1'b1; step(); step();
    reset = 1'b0; step(); step();
    check("post_reset_count", 32'(bus.taken_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
